// File: rtl/unary_window_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : unary_window_ctrl_if
// Brief    : Request, unary bit stream and result handshake bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface unary_window_ctrl_if #(
    parameter int ACC_WIDTH = 8,
    parameter int LEN_WIDTH = 8
);
    logic                 start;
    logic [LEN_WIDTH-1:0] win_len;
    logic                 abort;
    logic                 busy;
    logic                 bit_valid;
    logic                 bit_in;
    logic                 bit_ready;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_WIDTH-1:0] res_data;
    logic                 res_ovf;

    modport master (
        output start, win_len, abort, bit_valid, bit_in, res_ready,
        input  busy, bit_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  start, win_len, abort, bit_valid, bit_in, res_ready,
        output busy, bit_ready, res_valid, res_data, res_ovf
    );
endinterface

`default_nettype wire

// File: rtl/unary_window_ctrl.sv
//------------------------------------------------------------------------------
// Module   : unary_window_ctrl
// Brief    : Counts the 1s of an N-bit unary window and returns one saturated result.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unary_window_ctrl #(
    parameter int ACC_WIDTH = 8,
    parameter int LEN_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    unary_window_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [ACC_WIDTH-1:0] CNT_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] rem_q,   rem_d;
    logic                 ovf_q,   ovf_d;
    logic                 w_accept;

    assign w_accept = (state_q == S_ACCUM) && bus.bit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                // abort outranks start here, so a coincident start is dropped
                if (bus.start && !bus.abort) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (bus.win_len != '0) begin
                        rem_d   = bus.win_len;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    rem_d   = '0;
                    ovf_d   = 1'b0;
                end else if (w_accept) begin
                    if (bus.bit_in) begin
                        if (&count_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result fields track the registers directly so they stay put after delivery.
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.bit_ready = (state_q == S_ACCUM);
        bus.res_valid = (state_q == S_DONE);
        bus.res_data  = count_q;
        bus.res_ovf   = ovf_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_unary_window_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_unary_window_ctrl
// Brief    : Directed bench for unary_window_ctrl (8-bit and 4-bit count builds).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_unary_window_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    unary_window_ctrl_if #(.ACC_WIDTH(8), .LEN_WIDTH(8)) bus_a ();
    unary_window_ctrl_if #(.ACC_WIDTH(4), .LEN_WIDTH(8)) bus_b ();

    unary_window_ctrl #(.ACC_WIDTH(8), .LEN_WIDTH(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    unary_window_ctrl #(.ACC_WIDTH(4), .LEN_WIDTH(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0] pat;
        total = 0;
        bad   = 0;

        bus_a.start = 0; bus_a.win_len = '0; bus_a.abort = 0;
        bus_a.bit_valid = 0; bus_a.bit_in = 0; bus_a.res_ready = 0;
        bus_b.start = 0; bus_b.win_len = '0; bus_b.abort = 0;
        bus_b.bit_valid = 0; bus_b.bit_in = 0; bus_b.res_ready = 0;

        // reset values
        rst_n = 0;
        tick(); tick();
        check("rst_busy",  bus_a.busy, 0);
        check("rst_ready", bus_a.bit_ready, 0);
        check("rst_valid", bus_a.res_valid, 0);
        check("rst_data",  bus_a.res_data, 0);
        check("rst_ovf",   bus_a.res_ovf, 0);
        @(negedge clk); rst_n = 1;
        tick();

        // window of 5, stream 1,0,1,1,0 -> 3
        bus_a.start = 1; bus_a.win_len = 8'd5;
        tick();
        bus_a.start = 0;
        check("w5_busy",  bus_a.busy, 1);
        check("w5_ready", bus_a.bit_ready, 1);
        pat = 5'b01101;
        bus_a.bit_valid = 1;
        for (int i = 0; i < 5; i++) begin
            bus_a.bit_in = pat[i];
            check("w5_novalid", bus_a.res_valid, 0);
            tick();
        end
        bus_a.bit_valid = 0; bus_a.bit_in = 0;
        check("w5_valid", bus_a.res_valid, 1);
        check("w5_data",  bus_a.res_data, 3);
        check("w5_ovf",   bus_a.res_ovf, 0);
        check("w5_rdy0",  bus_a.bit_ready, 0);
        bus_a.res_ready = 1;
        tick();
        bus_a.res_ready = 0;
        check("w5_idle_busy",  bus_a.busy, 0);
        check("w5_idle_valid", bus_a.res_valid, 0);
        check("w5_hold_data",  bus_a.res_data, 3);

        // window of 4 with bit_valid toggling -> 4, then back-pressure
        bus_a.start = 1; bus_a.win_len = 8'd4;
        tick();
        bus_a.start = 0;
        bus_a.bit_in = 1;
        for (int i = 0; i < 8; i++) begin
            bus_a.bit_valid = (i % 2 == 0);
            tick();
        end
        bus_a.bit_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("w4_valid", bus_a.res_valid, 1);
            check("w4_data",  bus_a.res_data, 4);
            tick();
        end
        bus_a.res_ready = 1;
        tick();
        bus_a.res_ready = 0;
        check("w4_idle", bus_a.busy, 0);

        // 4-bit build: window of 20 all ones saturates
        bus_b.start = 1; bus_b.win_len = 8'd20;
        tick();
        bus_b.start = 0;
        bus_b.bit_valid = 1; bus_b.bit_in = 1;
        for (int i = 0; i < 20; i++) begin
            check("sat_novalid", bus_b.res_valid, 0);
            tick();
        end
        bus_b.bit_valid = 0;
        check("sat_valid", bus_b.res_valid, 1);
        check("sat_data",  bus_b.res_data, 15);
        check("sat_ovf",   bus_b.res_ovf, 1);
        bus_b.res_ready = 1;
        tick();
        bus_b.res_ready = 0;
        check("sat_idle", bus_b.busy, 0);

        // empty window
        bus_a.start = 1; bus_a.win_len = 8'd0;
        tick();
        bus_a.start = 0;
        check("w0_valid", bus_a.res_valid, 1);
        check("w0_data",  bus_a.res_data, 0);
        check("w0_ovf",   bus_a.res_ovf, 0);
        check("w0_ready", bus_a.bit_ready, 0);
        bus_a.res_ready = 1;
        tick();
        bus_a.res_ready = 0;
        check("w0_idle", bus_a.busy, 0);

        // abort after 3 accepted ones, then clean window of 2
        bus_a.start = 1; bus_a.win_len = 8'd8;
        tick();
        bus_a.start = 0;
        bus_a.bit_valid = 1; bus_a.bit_in = 1;
        tick(); tick(); tick();
        check("ab_data3", bus_a.res_data, 3);
        bus_a.abort = 1;
        tick();
        bus_a.abort = 0; bus_a.bit_valid = 0;
        check("ab_busy",  bus_a.busy, 0);
        check("ab_valid", bus_a.res_valid, 0);
        check("ab_data",  bus_a.res_data, 0);
        tick();
        check("ab_stay",  bus_a.res_valid, 0);
        bus_a.start = 1; bus_a.win_len = 8'd2;
        tick();
        bus_a.start = 0;
        bus_a.bit_valid = 1; bus_a.bit_in = 1;
        tick(); tick();
        bus_a.bit_valid = 0;
        check("ab2_valid", bus_a.res_valid, 1);
        check("ab2_data",  bus_a.res_data, 2);
        bus_a.res_ready = 1;
        tick();
        bus_a.res_ready = 0;

        // stray start during ACCUM and at the DONE handshake
        bus_a.start = 1; bus_a.win_len = 8'd6;
        tick();
        bus_a.start = 0;
        bus_a.bit_valid = 1; bus_a.bit_in = 1;
        tick(); tick();
        bus_a.bit_valid = 0;
        bus_a.start = 1; bus_a.win_len = 8'd1;
        tick();
        bus_a.start = 0;
        check("st_busy", bus_a.busy, 1);
        check("st_cnt",  bus_a.res_data, 2);
        bus_a.bit_valid = 1;
        for (int i = 0; i < 4; i++) begin
            check("st_novalid", bus_a.res_valid, 0);
            tick();
        end
        bus_a.bit_valid = 0;
        check("st_valid", bus_a.res_valid, 1);
        check("st_data",  bus_a.res_data, 6);
        bus_a.res_ready = 1; bus_a.start = 1; bus_a.win_len = 8'd3;
        tick();
        bus_a.res_ready = 0; bus_a.start = 0;
        check("hs_busy",  bus_a.busy, 0);
        tick();
        check("hs_busy2", bus_a.busy, 0);

        // asynchronous reset mid-window
        bus_a.start = 1; bus_a.win_len = 8'd5;
        tick();
        bus_a.start = 0;
        bus_a.bit_valid = 1; bus_a.bit_in = 1;
        tick(); tick();
        check("ar_pre", bus_a.res_data, 2);
        #1 rst_n = 0;
        #1;
        check("ar_busy",  bus_a.busy, 0);
        check("ar_ready", bus_a.bit_ready, 0);
        check("ar_data",  bus_a.res_data, 0);
        check("ar_valid", bus_a.res_valid, 0);
        bus_a.bit_valid = 0;
        @(negedge clk); rst_n = 1;
        tick();
        check("ar_after", bus_a.busy, 0);
        bus_a.start = 1; bus_a.win_len = 8'd1;
        tick();
        bus_a.start = 0;
        bus_a.bit_valid = 1; bus_a.bit_in = 1;
        tick();
        bus_a.bit_valid = 0;
        check("ar_w1_valid", bus_a.res_valid, 1);
        check("ar_w1_data",  bus_a.res_data, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
